// File: rtl/icache_assoc_if.sv
// Bundle of the fetch-side and memory-side signals of the set-associative icache.
// The cache uses the slave view; whoever drives fetches and serves memory uses master.
interface icache_assoc_if #(
    parameter int CNT_W = 16
);
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             halt;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  imemREN, imemaddr, halt, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
    );

    modport master (
        output imemREN, imemaddr, halt, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU replacement, multi-word block fill,
// halt-flush and saturating hit/miss counters. Hits return combinationally.
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    parameter int CNT_W = 16
) (
    input  logic           CLK,
    input  logic           nRST,
    icache_assoc_if.slave  bus
);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int WOFF_BITS = $clog2(WORDS);
    localparam int WOFF_W    = (WORDS > 1) ? WOFF_BITS : 1;
    localparam int AGE_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W     = AGE_W;
    localparam int TAG_W     = 30 - IDX_BITS - WOFF_BITS;

    typedef enum logic {IDLE, FILL} state_t;
    state_t stateQ, stateD;

    logic             validQ [SETS][WAYS];
    logic [TAG_W-1:0] tagQ   [SETS][WAYS];
    logic [AGE_W-1:0] ageQ   [SETS][WAYS];
    logic [31:0]      dataQ  [SETS][WAYS][WORDS];

    logic [TAG_W-1:0]    fillTagQ;
    logic [IDX_BITS-1:0] fillIdxQ;
    logic [WAY_W-1:0]    victimQ;
    logic [WOFF_W-1:0]   kQ;
    logic [CNT_W-1:0]    hitCntQ, missCntQ;

    logic [29:0]         wordAddr, fillWordAddr;
    logic [IDX_BITS-1:0] reqIdx, accessIdx;
    logic [TAG_W-1:0]    reqTag;
    logic [WOFF_W-1:0]   reqWord;
    logic                tagMatch, lookupEn, hit, startFill;
    logic                wordAccept, lastWord, install, updateLru, foundFree;
    logic [WAY_W-1:0]    hitWay, victimWay, accessWay;
    logic [AGE_W-1:0]    maxAge, oldAge;

    assign wordAddr = bus.imemaddr[31:2];
    assign reqWord  = WOFF_W'(wordAddr & 30'(WORDS - 1));
    assign reqIdx   = IDX_BITS'(wordAddr >> WOFF_BITS);
    assign reqTag   = TAG_W'(wordAddr >> (WOFF_BITS + IDX_BITS));

    always_comb begin
        tagMatch = 1'b0;
        hitWay   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validQ[reqIdx][w] && tagQ[reqIdx][w] == reqTag) begin
                tagMatch = 1'b1;
                hitWay   = WAY_W'(w);
            end
        end
    end

    assign lookupEn  = bus.imemREN && !bus.halt && (stateQ == IDLE);
    assign hit       = lookupEn && tagMatch;
    assign startFill = lookupEn && !tagMatch;

    // Victim: lowest invalid way first, otherwise the oldest way of the set.
    always_comb begin
        victimWay = '0;
        foundFree = 1'b0;
        maxAge    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!foundFree && !validQ[reqIdx][w]) begin
                foundFree = 1'b1;
                victimWay = WAY_W'(w);
            end
        end
        if (!foundFree) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ageQ[reqIdx][w] > maxAge) begin
                    maxAge    = ageQ[reqIdx][w];
                    victimWay = WAY_W'(w);
                end
            end
        end
    end

    assign wordAccept   = (stateQ == FILL) && !bus.halt && !bus.iwait;
    assign lastWord     = (kQ == WOFF_W'(WORDS - 1));
    assign install      = wordAccept && lastWord;
    assign updateLru    = hit || install;
    assign accessWay    = install ? victimQ : hitWay;
    assign accessIdx    = install ? fillIdxQ : reqIdx;
    // An invalid way being installed counts as the oldest, so ages converge to a permutation after flush.
    assign oldAge       = (install && !validQ[fillIdxQ][victimQ]) ? AGE_W'(WAYS - 1)
                                                                  : ageQ[accessIdx][accessWay];
    assign fillWordAddr = (30'(fillTagQ) << (WOFF_BITS + IDX_BITS))
                        | (30'(fillIdxQ) << WOFF_BITS) | 30'(kQ);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    validQ[s][w] <= 1'b0;
                    tagQ[s][w]   <= '0;
                    ageQ[s][w]   <= '0;
                    for (int d = 0; d < WORDS; d++) dataQ[s][w][d] <= '0;
                end
            end
        end else if (bus.halt) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    validQ[s][w] <= 1'b0;
                    ageQ[s][w]   <= '0;
                end
            end
        end else begin
            if (wordAccept) dataQ[fillIdxQ][victimQ][kQ] <= bus.iload;
            if (install) begin
                validQ[fillIdxQ][victimQ] <= 1'b1;
                tagQ[fillIdxQ][victimQ]   <= fillTagQ;
            end
            if (updateLru && WAYS > 1) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == accessWay)
                        ageQ[accessIdx][w] <= '0;
                    else if (ageQ[accessIdx][w] < oldAge)
                        ageQ[accessIdx][w] <= ageQ[accessIdx][w] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fillTagQ <= '0;
            fillIdxQ <= '0;
            victimQ  <= '0;
            kQ       <= '0;
        end else if (bus.halt) begin
            kQ <= '0;
        end else if (startFill) begin
            fillTagQ <= reqTag;
            fillIdxQ <= reqIdx;
            victimQ  <= victimWay;
            kQ       <= '0;
        end else if (wordAccept) begin
            kQ <= kQ + WOFF_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitCntQ  <= '0;
            missCntQ <= '0;
        end else begin
            if (hit && hitCntQ != '1)        hitCntQ  <= hitCntQ + CNT_W'(1);
            if (startFill && missCntQ != '1) missCntQ <= missCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) stateQ <= IDLE;
        else       stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        if (bus.halt) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE:    if (startFill) stateD = FILL;
                FILL:    if (install)   stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ihit     = hit;
        bus.imemload = hit ? dataQ[reqIdx][hitWay][reqWord] : 32'h0;
        bus.iREN     = (stateQ == FILL) && !bus.halt;
        bus.iaddr    = (stateQ == FILL) ? {fillWordAddr, 2'b00} : 32'h0;
    end

    assign bus.hit_cnt  = hitCntQ;
    assign bus.miss_cnt = missCntQ;
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: per-cycle vector table for fill/LRU/stall flows,
// plus hand sequences for halt, address change, async reset and counter saturation.
module tb_icache_assoc;
    localparam int CNT_W = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   stallCfg = 0;
    int   waitCnt = 0;

    icache_assoc_if #(.CNT_W(CNT_W)) mif ();

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (mif)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h40) return 32'hAAAA_0001;
        if (a == 32'h44) return 32'hAAAA_0002;
        return 32'h5000_0000 | a;
    endfunction

    assign mif.iload = memData(mif.iaddr);

    typedef struct {
        bit          rst;
        bit          en;
        logic [31:0] addr;
        int          stall;
        bit          expHit;
        logic [31:0] expLoad;
        bit          expREN;
        logic [31:0] expIaddr;
        int          expHc;
        int          expMc;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit rst, input bit en, input logic [31:0] addr, input int stall,
                          input bit expHit, input logic [31:0] expLoad, input bit expREN,
                          input logic [31:0] expIaddr, input int expHc, input int expMc);
        vec_t v;
        v.rst = rst; v.en = en; v.addr = addr; v.stall = stall;
        v.expHit = expHit; v.expLoad = expLoad; v.expREN = expREN; v.expIaddr = expIaddr;
        v.expHc = expHc; v.expMc = expMc;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        nRST = 1'b0;
        mif.imemREN = 1'b0; mif.imemaddr = '0; mif.halt = 1'b0; mif.iwait = 1'b0;
        waitCnt = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Drives one cycle of fetch inputs, lets the memory model pick iwait, then parks on the negedge.
    task automatic applyStimulus(input bit en, input logic [31:0] addr, input bit hlt);
        @(posedge CLK); #1;
        mif.imemREN = en; mif.imemaddr = addr; mif.halt = hlt;
        #1;
        if (mif.iREN && waitCnt < stallCfg) begin
            mif.iwait = 1'b1;
            waitCnt++;
        end else begin
            mif.iwait = 1'b0;
            waitCnt = 0;
        end
        @(negedge CLK);
    endtask

    task automatic checkCounters(input string tag, input int hc, input int mc);
        checkOutput({tag, " hit_cnt"},  32'(mif.hit_cnt),  32'(hc));
        checkOutput({tag, " miss_cnt"}, 32'(mif.miss_cnt), 32'(mc));
    endtask

    initial begin
        mif.imemREN = 1'b0; mif.imemaddr = '0; mif.halt = 1'b0; mif.iwait = 1'b0;

        // Cold miss on 0x40 then hits on both words.
        addVec(1, 1, 32'h40, 0, 0, 0,            0, 0,     0, 0);
        addVec(0, 1, 32'h40, 0, 0, 0,            1, 32'h40, 0, 1);
        addVec(0, 1, 32'h40, 0, 0, 0,            1, 32'h44, 0, 1);
        addVec(0, 1, 32'h40, 0, 1, 32'hAAAA0001, 0, 0,     0, 1);
        addVec(0, 1, 32'h44, 0, 1, 32'hAAAA0002, 0, 0,     1, 1);
        addVec(0, 0, 32'h0,  0, 0, 0,            0, 0,     2, 1);
        // LRU eviction in set 0.
        addVec(1, 1, 32'h40, 0, 0, 0,            0, 0,     0, 0);
        addVec(0, 1, 32'h40, 0, 0, 0,            1, 32'h40, 0, 1);
        addVec(0, 1, 32'h40, 0, 0, 0,            1, 32'h44, 0, 1);
        addVec(0, 1, 32'h80, 0, 0, 0,            0, 0,     0, 1);
        addVec(0, 1, 32'h80, 0, 0, 0,            1, 32'h80, 0, 2);
        addVec(0, 1, 32'h80, 0, 0, 0,            1, 32'h84, 0, 2);
        addVec(0, 1, 32'h40, 0, 1, 32'hAAAA0001, 0, 0,     0, 2);
        addVec(0, 1, 32'hC0, 0, 0, 0,            0, 0,     1, 2);
        addVec(0, 1, 32'hC0, 0, 0, 0,            1, 32'hC0, 1, 3);
        addVec(0, 1, 32'hC0, 0, 0, 0,            1, 32'hC4, 1, 3);
        addVec(0, 1, 32'h40, 0, 1, 32'hAAAA0001, 0, 0,     1, 3);
        addVec(0, 1, 32'h80, 0, 0, 0,            0, 0,     2, 3);
        addVec(0, 1, 32'h80, 0, 0, 0,            1, 32'h80, 2, 4);
        addVec(0, 1, 32'h80, 0, 0, 0,            1, 32'h84, 2, 4);
        addVec(0, 1, 32'h80, 0, 1, 32'h50000080, 0, 0,     2, 4);
        addVec(0, 0, 32'h0,  0, 0, 0,            0, 0,     3, 4);
        // Memory stall of 3 cycles before each word of 0x100.
        addVec(1, 1, 32'h100, 3, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) addVec(0, 1, 32'h100, 3, 0, 0, 1, 32'h100, 0, 1);
        for (int c = 0; c < 4; c++) addVec(0, 1, 32'h100, 3, 0, 0, 1, 32'h104, 0, 1);
        addVec(0, 1, 32'h100, 3, 1, 32'h50000100, 0, 0, 0, 1);
        addVec(0, 0, 32'h0,   3, 0, 0,            0, 0, 1, 1);

        doReset();
        $display("[TB] reset state");
        checkOutput("reset ihit",     32'(mif.ihit), 32'd0);
        checkOutput("reset iREN",     32'(mif.iREN), 32'd0);
        checkOutput("reset iaddr",    mif.iaddr,     32'd0);
        checkOutput("reset imemload", mif.imemload,  32'd0);
        checkCounters("reset", 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            if (vecs[i].rst) doReset();
            stallCfg = vecs[i].stall;
            applyStimulus(vecs[i].en, vecs[i].addr, 1'b0);
            checkOutput({tag, " ihit"},     32'(mif.ihit), 32'(vecs[i].expHit));
            checkOutput({tag, " imemload"}, mif.imemload,  vecs[i].expLoad);
            checkOutput({tag, " iREN"},     32'(mif.iREN), 32'(vecs[i].expREN));
            if (vecs[i].expREN) checkOutput({tag, " iaddr"}, mif.iaddr, vecs[i].expIaddr);
            checkCounters(tag, vecs[i].expHc, vecs[i].expMc);
        end

        $display("[TB] halt mid-fill");
        stallCfg = 0;
        doReset();
        repeat (3) applyStimulus(1'b1, 32'h80, 1'b0);
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("halt pre hit",  32'(mif.ihit), 32'd1);
        checkOutput("halt pre load", mif.imemload,  32'h5000_0080);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkOutput("halt miss ihit", 32'(mif.ihit), 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkOutput("halt word0 iaddr", mif.iaddr, 32'h40);
        applyStimulus(1'b1, 32'h40, 1'b1);
        checkOutput("halted iREN", 32'(mif.iREN), 32'd0);
        checkOutput("halted ihit", 32'(mif.ihit), 32'd0);
        applyStimulus(1'b1, 32'h80, 1'b1);
        checkOutput("halted ihit 0x80", 32'(mif.ihit), 32'd0);
        checkOutput("halted iREN 2",    32'(mif.iREN), 32'd0);
        checkCounters("halted", 1, 2);
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("post halt miss", 32'(mif.ihit), 32'd0);
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("refill word0 iaddr", mif.iaddr,     32'h80);
        checkOutput("refill iREN",        32'(mif.iREN), 32'd1);
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("refill word1 iaddr", mif.iaddr, 32'h84);
        applyStimulus(1'b1, 32'h80, 1'b0);
        checkOutput("refill hit", mif.imemload, 32'h5000_0080);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkCounters("halt end", 2, 3);

        $display("[TB] address change mid-fill");
        doReset();
        applyStimulus(1'b1, 32'h40, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkOutput("chg word0 iaddr", mif.iaddr, 32'h40);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("chg word1 iaddr", mif.iaddr,     32'h44);
        checkOutput("chg fill ihit",   32'(mif.ihit), 32'd0);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("chg new miss", 32'(mif.ihit), 32'd0);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("chg new word0", mif.iaddr, 32'h200);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("chg new word1", mif.iaddr, 32'h204);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("chg new hit", mif.imemload, 32'h5000_0200);
        checkCounters("chg", 0, 2);

        $display("[TB] async reset mid-fill");
        doReset();
        applyStimulus(1'b1, 32'h40, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkOutput("rst fill iREN", 32'(mif.iREN), 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("rst drop iREN", 32'(mif.iREN), 32'd0);
        checkCounters("rst drop", 0, 0);

        $display("[TB] hit counter saturation");
        doReset();
        repeat (3) applyStimulus(1'b1, 32'h40, 1'b0);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, 32'h40, 1'b0);
            checkOutput($sformatf("sat hit%0d", n), 32'(mif.ihit), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkCounters("sat", 15, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
